// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: shared types and constants for the AHB-to-APB bridge.
//   state_t      : APB sequencer state encoding (8 states)
//   *_DEF        : default address/data widths and number of APB selects
//   SLVn_BASE    : APB slave base addresses used by the address decoder
//   is_enable()  : true for the three APB enable-phase states
package apb_bridge_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int NSEL_DEF   = 3;

  localparam logic [31:0] SLV0_BASE = 32'h8000_0000;
  localparam logic [31:0] SLV1_BASE = 32'h8400_0000;
  localparam logic [31:0] SLV2_BASE = 32'h8800_0000;
  localparam logic [31:0] SLV3_BASE = 32'h8c00_0000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WWAIT    = 3'd1,
    ST_READ     = 3'd2,
    ST_WRITE    = 3'd3,
    ST_WRITEP   = 3'd4,
    ST_RENABLE  = 3'd5,
    ST_WENABLE  = 3'd6,
    ST_WENABLEP = 3'd7
  } state_t;

  function automatic logic is_enable(input state_t s);
    return (s == ST_RENABLE) || (s == ST_WENABLE) || (s == ST_WENABLEP);
  endfunction

endpackage

// File: rtl/apb_fsm_controller.sv
// apb_fsm_controller: APB sequencer of the AHB-to-APB bridge.
// Takes qualified AHB transfers from the slave interface and runs APB
// setup/enable phases, inserting AHB wait states via hreadyout.
//
// Ports:
//   hclk, hresetn         clock, async active-low reset
//   valid                 qualified AHB transfer in address phase
//   hwrite, hwritereg     live / one-cycle-delayed AHB direction
//   haddr, haddr1, haddr2 live / 1-cycle / 2-cycle delayed address
//   hwdata, hwdata1       live / 1-cycle delayed write data
//   tempselx              decoded one-hot slave select
//   pwrite, penable, pselx, paddr, pwdata   APB master outputs (registered)
//   hreadyout             AHB ready back to master (registered)
//   pready                only with APB_PREADY_EN: APB slave ready
//
// Build option: define APB_PREADY_EN to add the pready input and let
// enable phases stretch until the slave is ready.
module apb_fsm_controller
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int NSEL   = NSEL_DEF
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              valid,
  input  logic              hwrite,
  input  logic              hwritereg,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [ADDR_W-1:0] haddr1,
  input  logic [ADDR_W-1:0] haddr2,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hwdata1,
  input  logic [NSEL-1:0]   tempselx,
  output logic              pwrite,
  output logic              penable,
  output logic [NSEL-1:0]   pselx,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              hreadyout
`ifdef APB_PREADY_EN
  ,
  input  logic              pready
`endif
);

`ifdef APB_PREADY_EN
  // Outputs are registered, so the enable phase cannot know in advance
  // whether pready will be high; the AHB side is held off for the whole
  // enable phase and released on the cycle after the slave completes.
  localparam logic ENABLE_READY = 1'b0;
  logic apb_ready;
  assign apb_ready = pready;
`else
  localparam logic ENABLE_READY = 1'b1;
  logic apb_ready;
  assign apb_ready = 1'b1;
`endif

  state_t state, next_state;

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:
        if (valid) next_state = hwrite ? ST_WWAIT : ST_READ;
      ST_WWAIT:
        next_state = valid ? ST_WRITEP : ST_WRITE;
      ST_READ:
        next_state = ST_RENABLE;
      ST_WRITE:
        next_state = valid ? ST_WENABLEP : ST_WENABLE;
      ST_WRITEP:
        next_state = ST_WENABLEP;
      ST_RENABLE, ST_WENABLE: begin
        if (apb_ready) begin
          if (valid) next_state = hwrite ? ST_WWAIT : ST_READ;
          else       next_state = ST_IDLE;
        end
      end
      ST_WENABLEP: begin
        if (apb_ready) begin
          if (!hwritereg)  next_state = ST_READ;
          else if (valid)  next_state = ST_WRITEP;
          else             next_state = ST_WRITE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs are a function of the state being entered; for writes the
  // source state picks which pipeline tap holds the transfer's addr/data.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= ST_IDLE;
      pselx     <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      hreadyout <= 1'b1;
    end else begin
      state <= next_state;
      case (next_state)
        ST_IDLE, ST_WWAIT: begin
          pselx     <= '0;
          penable   <= 1'b0;
          hreadyout <= 1'b1;
        end
        ST_READ: begin
          paddr     <= haddr;
          pwrite    <= 1'b0;
          pselx     <= tempselx;
          penable   <= 1'b0;
          hreadyout <= 1'b0;
        end
        ST_WRITE, ST_WRITEP: begin
          if (state == ST_WENABLEP) begin
            paddr  <= haddr2;
            pwdata <= hwdata1;
          end else begin
            paddr  <= haddr1;
            pwdata <= hwdata;
          end
          pwrite    <= 1'b1;
          pselx     <= tempselx;
          penable   <= 1'b0;
          // WRITEP stalls the master while the second pipelined write's
          // data is still to be captured.
          hreadyout <= (next_state == ST_WRITE);
        end
        default: begin
          // enable states (entry or pready stall): hold addr/data/sel
          penable   <= 1'b1;
          hreadyout <= ENABLE_READY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed testbench for apb_fsm_controller. The AHB slave-interface
// pipeline taps (haddr1/2, hwdata1, hwritereg) are generated here from
// the live AHB signals the tasks drive.
module tb_apb_fsm_controller;
  import apb_bridge_pkg::*;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        valid, hwrite, hwritereg;
  logic [31:0] haddr, haddr1, haddr2, hwdata, hwdata1;
  logic [2:0]  tempselx;
  logic        pwrite, penable, hreadyout;
  logic [2:0]  pselx;
  logic [31:0] paddr, pwdata;
`ifdef APB_PREADY_EN
  logic        pready;
`endif

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  always_ff @(posedge hclk) begin
    haddr1    <= haddr;
    haddr2    <= haddr1;
    hwdata1   <= hwdata;
    hwritereg <= hwrite;
  end

  apb_fsm_controller dut (
    .hclk(hclk), .hresetn(hresetn), .valid(valid), .hwrite(hwrite),
    .hwritereg(hwritereg), .haddr(haddr), .haddr1(haddr1), .haddr2(haddr2),
    .hwdata(hwdata), .hwdata1(hwdata1), .tempselx(tempselx),
    .pwrite(pwrite), .penable(penable), .pselx(pselx), .paddr(paddr),
    .pwdata(pwdata), .hreadyout(hreadyout)
`ifdef APB_PREADY_EN
    , .pready(pready)
`endif
  );

  // {pselx, penable, pwrite, hreadyout}
  logic [5:0] ctl;
  assign ctl = {pselx, penable, pwrite, hreadyout};

  task automatic edge_drive();
    @(posedge hclk); #1;
  endtask

  task automatic test_reset();
    @(negedge hclk);
    checks++;
    if (ctl !== 6'b000_001 || paddr !== 32'h0 || pwdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: ctl=%b paddr=%h pwdata=%h, want ctl=000001 paddr=0 pwdata=0",
               ctl, paddr, pwdata);
    end
    // idle with no valid stays idle
    edge_drive(); @(negedge hclk);
    checks++;
    if (ctl !== 6'b000_001) begin
      errors++; $display("FAIL idle_hold: ctl=%b want 000001", ctl);
    end
  endtask

  task automatic test_single_read();
    edge_drive();
    valid = 1; hwrite = 0; haddr = 32'h8000_0010; tempselx = 3'b001;
    edge_drive(); valid = 0;
    @(negedge hclk); checks++;
    if (ctl !== 6'b001_0_0_0 || paddr !== 32'h8000_0010) begin
      errors++; $display("FAIL read_setup: ctl=%b paddr=%h want ctl=001000 paddr=80000010", ctl, paddr);
    end
    edge_drive(); @(negedge hclk); checks++;
    if (ctl !== 6'b001_1_0_1 || paddr !== 32'h8000_0010) begin
      errors++; $display("FAIL read_enable: ctl=%b paddr=%h want ctl=001101 paddr=80000010", ctl, paddr);
    end
    edge_drive(); @(negedge hclk); checks++;
    if (ctl !== 6'b000_0_0_1) begin
      errors++; $display("FAIL read_done: ctl=%b want 000001", ctl);
    end
  endtask

  task automatic test_single_write();
    int lowcnt = 0;
    edge_drive();
    valid = 1; hwrite = 1; haddr = 32'h8400_0004; tempselx = 3'b010;
    edge_drive(); valid = 0; hwdata = 32'hDEAD_BEEF;
    @(negedge hclk); if (!hreadyout) lowcnt++;
    checks++;
    if (ctl !== 6'b000_0_0_1) begin
      errors++; $display("FAIL write_wwait: ctl=%b want 000001", ctl);
    end
    edge_drive(); hwdata = 32'h0;
    @(negedge hclk); if (!hreadyout) lowcnt++;
    checks++;
    if (ctl !== 6'b010_0_1_1 || paddr !== 32'h8400_0004 || pwdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL write_setup: ctl=%b paddr=%h pwdata=%h want ctl=010011 paddr=84000004 pwdata=deadbeef",
                         ctl, paddr, pwdata);
    end
    edge_drive(); @(negedge hclk); if (!hreadyout) lowcnt++;
    checks++;
`ifdef APB_PREADY_EN
    if (ctl !== 6'b010_1_1_0) begin
      errors++; $display("FAIL write_enable: ctl=%b want 010110", ctl);
    end
`else
    if (ctl !== 6'b010_1_1_1) begin
      errors++; $display("FAIL write_enable: ctl=%b want 010111", ctl);
    end
`endif
    edge_drive(); @(negedge hclk); if (!hreadyout) lowcnt++;
    checks++;
    if (ctl !== 6'b000_0_1_1 || pwdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL write_done: ctl=%b pwdata=%h want ctl=000011 pwdata=deadbeef", ctl, pwdata);
    end
`ifndef APB_PREADY_EN
    checks++;
    if (lowcnt !== 0) begin
      errors++; $display("FAIL write_no_wait: hreadyout low %0d cycles want 0", lowcnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int lowcnt = 0;
    edge_drive();
    valid = 1; hwrite = 1; haddr = 32'h8800_0000; tempselx = 3'b100;
    edge_drive(); haddr = 32'h8800_0004; hwdata = 32'h11;          // -> WWAIT
    @(negedge hclk); if (!hreadyout) lowcnt++;
    edge_drive(); valid = 0; hwdata = 32'h22;                       // -> WRITEP
    @(negedge hclk); if (!hreadyout) lowcnt++;
    checks++;
    if (ctl !== 6'b100_0_1_0 || paddr !== 32'h8800_0000 || pwdata !== 32'h11) begin
      errors++; $display("FAIL b2b_setup1: ctl=%b paddr=%h pwdata=%h want ctl=100010 paddr=88000000 pwdata=11",
                         ctl, paddr, pwdata);
    end
    edge_drive(); hwdata = 32'h0;                                   // -> WENABLEP
    @(negedge hclk); if (!hreadyout) lowcnt++;
    checks++;
    if (ctl !== 6'b100_1_1_1 || paddr !== 32'h8800_0000) begin
      errors++; $display("FAIL b2b_enable1: ctl=%b paddr=%h want ctl=100111 paddr=88000000", ctl, paddr);
    end
    edge_drive();                                                   // -> WRITE
    @(negedge hclk); if (!hreadyout) lowcnt++;
    checks++;
    if (ctl !== 6'b100_0_1_1 || paddr !== 32'h8800_0004 || pwdata !== 32'h22) begin
      errors++; $display("FAIL b2b_setup2: ctl=%b paddr=%h pwdata=%h want ctl=100011 paddr=88000004 pwdata=22",
                         ctl, paddr, pwdata);
    end
    edge_drive();                                                   // -> WENABLE
    @(negedge hclk); if (!hreadyout) lowcnt++;
    checks++;
    if (ctl !== 6'b100_1_1_1) begin
      errors++; $display("FAIL b2b_enable2: ctl=%b want 100111", ctl);
    end
    edge_drive();                                                   // -> IDLE
    @(negedge hclk); if (!hreadyout) lowcnt++;
    checks++;
    if (ctl !== 6'b000_0_1_1) begin
      errors++; $display("FAIL b2b_done: ctl=%b want 000011", ctl);
    end
    checks++;
    if (lowcnt !== 1) begin
      errors++; $display("FAIL b2b_wait_states: hreadyout low %0d cycles want 1", lowcnt);
    end
  endtask

  task automatic test_write_then_read();
    edge_drive();
    valid = 1; hwrite = 1; haddr = 32'h8000_0000; tempselx = 3'b001;
    edge_drive(); hwrite = 0; haddr = 32'h8000_0008; hwdata = 32'h33; // -> WWAIT
    edge_drive(); valid = 0;                                          // -> WRITEP
    @(negedge hclk); checks++;
    if (ctl !== 6'b001_0_1_0 || paddr !== 32'h8000_0000 || pwdata !== 32'h33) begin
      errors++; $display("FAIL wr_rd_wsetup: ctl=%b paddr=%h pwdata=%h want ctl=001010 paddr=80000000 pwdata=33",
                         ctl, paddr, pwdata);
    end
    edge_drive();                                                     // -> WENABLEP
    @(negedge hclk); checks++;
    if (ctl !== 6'b001_1_1_1) begin
      errors++; $display("FAIL wr_rd_wenable: ctl=%b want 001111", ctl);
    end
    edge_drive();                                                     // -> READ
    @(negedge hclk); checks++;
    if (ctl !== 6'b001_0_0_0 || paddr !== 32'h8000_0008) begin
      errors++; $display("FAIL wr_rd_rsetup: ctl=%b paddr=%h want ctl=001000 paddr=80000008", ctl, paddr);
    end
    edge_drive();                                                     // -> RENABLE
    @(negedge hclk); checks++;
    if (ctl !== 6'b001_1_0_1) begin
      errors++; $display("FAIL wr_rd_renable: ctl=%b want 001101", ctl);
    end
    edge_drive();
    @(negedge hclk); checks++;
    if (ctl !== 6'b000_0_0_1) begin
      errors++; $display("FAIL wr_rd_done: ctl=%b want 000001", ctl);
    end
  endtask

  task automatic test_async_reset();
    edge_drive();
    valid = 1; hwrite = 0; haddr = 32'h8400_0020; tempselx = 3'b010;
    edge_drive(); valid = 0;                                          // -> READ
    edge_drive();                                                     // -> RENABLE
    @(negedge hclk); checks++;
    if (penable !== 1'b1) begin
      errors++; $display("FAIL rst_pre_enable: penable=%b want 1", penable);
    end
    #2 hresetn = 0;
    #1 checks++;
    if (ctl !== 6'b000_0_0_1 || paddr !== 32'h0 || pwdata !== 32'h0) begin
      errors++; $display("FAIL rst_async: ctl=%b paddr=%h pwdata=%h want ctl=000001 paddr=0 pwdata=0",
                         ctl, paddr, pwdata);
    end
    edge_drive(); hresetn = 1;
    edge_drive(); @(negedge hclk); checks++;
    if (ctl !== 6'b000_0_0_1) begin
      errors++; $display("FAIL rst_idle_after: ctl=%b want 000001", ctl);
    end
  endtask

`ifdef APB_PREADY_EN
  task automatic test_pready_stall();
    edge_drive();
    valid = 1; hwrite = 0; haddr = 32'h8c00_0000; tempselx = 3'b100;
    edge_drive(); valid = 0; pready = 0;                              // -> READ
    edge_drive();                                                     // -> RENABLE
    for (int k = 0; k < 3; k++) begin
      @(negedge hclk); checks++;
      if (ctl !== 6'b100_1_0_0) begin
        errors++; $display("FAIL pready_hold%0d: ctl=%b want 100100", k, ctl);
      end
      if (k == 2) begin
        edge_drive(); pready = 1;  // 4th RENABLE cycle sees pready high
      end else begin
        edge_drive();
      end
    end
    edge_drive();                                                     // -> IDLE
    @(negedge hclk); checks++;
    if (ctl !== 6'b000_0_0_1) begin
      errors++; $display("FAIL pready_exit: ctl=%b want 000001", ctl);
    end
  endtask
`endif

  initial begin
    hresetn = 0; valid = 0; hwrite = 0; haddr = '0; hwdata = '0; tempselx = '0;
`ifdef APB_PREADY_EN
    pready = 1;
`endif
    #12 hresetn = 1;
    test_reset();
    test_single_read();
    test_single_write();
`ifndef APB_PREADY_EN
    test_back_to_back();
    test_write_then_read();
`else
    test_pready_stall();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_fsm_controller.md
Name: apb_fsm_controller

Overview:
- Downstream stage of the AHB slave interface in the AHB-to-APB bridge.
- Consumes the slave interface's outputs: valid, tempselx, pipelined address/data, and registered hwrite.
- Sequences APB setup and enable phases; drives paddr/pwdata/pwrite/pselx/penable.
- Returns hreadyout to the AHB side to insert wait states.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- NSEL, 3, number of one-hot APB slave selects

Ports:
- hclk  in  1  bridge clock; all state changes on rising edge
- hresetn  in  1  reset, asynchronous and active-low
- valid  in  1  qualified AHB transfer in address phase (from slave interface)
- hwrite  in  1  live AHB hwrite of current address phase
- hwritereg  in  1  hwrite registered one cycle
- haddr  in  ADDR_W  live AHB address
- haddr1  in  ADDR_W  haddr delayed 1 cycle
- haddr2  in  ADDR_W  haddr delayed 2 cycles
- hwdata  in  DATA_W  live AHB write data
- hwdata1  in  DATA_W  hwdata delayed 1 cycle
- tempselx  in  NSEL  decoded one-hot slave select
- pwrite  out  1  APB direction
- penable  out  1  APB enable phase
- pselx  out  NSEL  APB one-hot select
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- hreadyout  out  1  AHB ready back to master

Behaviour:
- All outputs are registered.
- Reset (async, hresetn=0): state=ST_IDLE; pselx=0, penable=0, pwrite=0, paddr=0, pwdata=0, hreadyout=1. Reset mid-transfer abandons it immediately.
- States: ST_IDLE, ST_WWAIT, ST_READ, ST_WRITE, ST_WRITEP, ST_RENABLE, ST_WENABLE, ST_WENABLEP.
- Transitions:
  - IDLE: valid&!hwrite->READ; valid&hwrite->WWAIT; else IDLE.
  - WWAIT: valid->WRITEP; else WRITE.
  - READ->RENABLE.
  - WRITE: valid->WENABLEP; else WENABLE.
  - WRITEP->WENABLEP.
  - RENABLE, WENABLE: same as IDLE.
  - WENABLEP: !hwritereg->READ; valid&hwritereg->WRITEP; else WRITE.
- Entering READ: paddr=haddr, pwrite=0, pselx=tempselx, penable=0, hreadyout=0.
- Entering WRITE/WRITEP:
  - From WWAIT: paddr=haddr1, pwdata=hwdata.
  - From WENABLEP: paddr=haddr2, pwdata=hwdata1.
  - In both cases: pwrite=1, pselx=tempselx, penable=0.
  - hreadyout=1 for WRITE, 0 for WRITEP.
- Entering any ENABLE state: penable=1, hreadyout=1; paddr/pwdata/pwrite/pselx held.
- Entering IDLE or WWAIT: pselx=0, penable=0, hreadyout=1; paddr/pwdata/pwrite held.
- Latency:
  - Read: 2 APB cycles (setup+enable); one AHB wait state.
  - Single write: WWAIT, setup, enable = 3 cycles; no wait state.
  - Back-to-back writes: one wait state per pipelined pair.
- Invariants:
  - penable=1 only in the cycle directly following a setup cycle with identical pselx.
  - pselx is 0 or one-hot.
  - tempselx=0 while valid=1 cannot occur (decoder gates valid); the FSM does not check it.

Optional Feature:
- APB_PREADY_EN: adds input pready (1 bit).
  - With it: RENABLE/WENABLE/WENABLEP hold state and all outputs (penable=1, hreadyout=0) until pready=1; the exit transition is then evaluated as above.
  - Without it: pready is treated as constant 1; enable states last exactly 1 cycle.

Decomposition:
- Package apb_bridge_pkg: state enum (8 encodings), NSEL, ADDR_W/DATA_W defaults, slave base-address constants 32'h8000_0000 / 32'h8400_0000 / 32'h8800_0000 / 32'h8c00_0000.
- Single module; no natural sub-module. Next-state and output logic stay in one registered process plus a combinational next-state process.

Test Plan:
- Reset: assert hresetn=0 asynchronously mid-RENABLE -> outputs reset immediately, without waiting for a clock edge: pselx=0, penable=0, hreadyout=1, state=ST_IDLE.
- Single read at haddr=32'h8000_0010, tempselx=3'b001 -> next cycle paddr=32'h8000_0010, pwrite=0, pselx=001, penable=0, hreadyout=0; following cycle penable=1, hreadyout=1; then pselx=0.
- Single write at 32'h8400_0004, data 32'hDEAD_BEEF -> WWAIT, then paddr=32'h8400_0004, pwdata=32'hDEADBEEF, pselx=010, pwrite=1; next cycle penable=1; hreadyout never 0.
- Back-to-back writes to 32'h8800_0000 and 32'h8800_0004 (data 11, 22) -> path WWAIT, WRITEP, WENABLEP, WRITE, WENABLE:
  - First setup: paddr ...0000 / pwdata 11.
  - Second setup: paddr ...0004 / pwdata 22.
  - hreadyout=0 for exactly 1 cycle.
- Write followed by read (32'h8000_0000 write, 32'h8000_0008 read) -> WENABLEP->READ; read setup uses paddr=32'h8000_0008, pwrite=0.
- APB_PREADY_EN: read with pready low 3 cycles -> penable=1, hreadyout=0 held 3 cycles; exit on pready=1.
